// File: rtl/reg_dump.sv
// reg_dump: dumps registers R0..R7 as a serial MSB-first frame followed by
// an XOR checksum byte.
//
// Handshake: there is no ready/backpressure on the serial side. A bit is
// transferred on every enabled clock edge where SerValid=1; Cen=0 stalls the
// whole block, so SerOut/SerValid/SerLast hold until the next enabled edge.
// Start is a request that is only honoured in IDLE; Abort cancels a frame
// from any non-IDLE state.
//
// Frame timing with Cen=1: Start edge -> LOAD, then per register one LOAD
// cycle plus eight SHIFT cycles, eight CKSUM cycles and one DONE cycle
// (81 busy cycles), returning to IDLE on the 82nd enabled edge.
module reg_dump (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Cen,
  input  logic       Start,
  input  logic       Abort,
  input  logic [7:0] RegData,
  output logic [2:0] RegSel,
  output logic       SerOut,
  output logic       SerValid,
  output logic       SerLast,
  output logic       Busy,
  output logic       Done,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CKSUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] regsel_q, regsel_d;
  logic [7:0] sreg_q, sreg_d;
  logic [7:0] csum_q, csum_d;
  logic [2:0] cnt_q, cnt_d;

  // State register: Rst wins over Cen; Cen=0 freezes every register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      regsel_q <= 3'd0;
      sreg_q   <= 8'h00;
      csum_q   <= 8'h00;
      cnt_q    <= 3'd0;
    end else if (Cen) begin
      state_q  <= state_d;
      regsel_q <= regsel_d;
      sreg_q   <= sreg_d;
      csum_q   <= csum_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic: sequencing of load / shift / checksum phases.
  always_comb begin
    state_d  = state_q;
    regsel_d = regsel_q;
    sreg_d   = sreg_q;
    csum_d   = csum_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // RegSel parks at 0 so a new frame always starts from R0.
        regsel_d = 3'd0;
        if (Start) begin
          state_d = S_LOAD;
          csum_d  = 8'h00;
          cnt_d   = 3'd0;
        end
      end

      S_LOAD: begin
        // RegData is combinational from RegSel, so it is valid this cycle.
        sreg_d  = RegData;
        csum_d  = csum_q ^ RegData;
        cnt_d   = 3'd0;
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        sreg_d = {sreg_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (regsel_q != 3'd7) begin
            regsel_d = regsel_q + 3'd1;
            state_d  = S_LOAD;
          end else begin
            // csum_q already includes R7 (folded in during its LOAD).
            sreg_d  = csum_q;
            cnt_d   = 3'd0;
            state_d = S_CKSUM;
          end
        end
      end

      S_CKSUM: begin
        sreg_d = {sreg_q[6:0], 1'b0};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Start is deliberately not looked at here.
        regsel_d = 3'd0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        regsel_d = 3'd0;
      end
    endcase

    // Abort cancels any frame in progress without a Done pulse.
    if (Abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      regsel_d = 3'd0;
    end
  end

  // Output decode: all outputs are functions of registered state only.
  always_comb begin
    SerOut   = 1'b0;
    SerValid = 1'b0;
    SerLast  = 1'b0;
    Done     = 1'b0;
    Busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_SHIFT: begin
        SerOut   = sreg_q[7];
        SerValid = 1'b1;
      end
      S_CKSUM: begin
        SerOut   = sreg_q[7];
        SerValid = 1'b1;
        SerLast  = (cnt_q == 3'd7);
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        SerOut = 1'b0;
      end
    endcase
  end

  assign RegSel    = regsel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: random and directed stimulus against a frame-level model.
// The model expands a Start into the list of per-cycle output vectors the
// frame must produce; a negedge process compares the DUT to it every cycle.
module tb_reg_dump;

  // ---------------- clock / reset ----------------
  logic       Clk = 1'b0;
  logic       Rst, Cen, Start, Abort;
  logic [7:0] RegData;
  logic [2:0] RegSel;
  logic       SerOut, SerValid, SerLast, Busy, Done;
  logic [2:0] dbg_state;

  always #5 Clk = ~Clk;

  logic [7:0] regs [8];
  assign RegData = regs[RegSel];

  reg_dump dut (
    .Clk(Clk), .Rst(Rst), .Cen(Cen), .Start(Start), .Abort(Abort),
    .RegData(RegData), .RegSel(RegSel), .SerOut(SerOut),
    .SerValid(SerValid), .SerLast(SerLast), .Busy(Busy), .Done(Done),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Vector layout: {Busy, SerValid, SerOut, SerLast, Done, RegSel[2:0]}
  logic [7:0] exp_q[$];
  logic [7:0] cur = 8'h00;
  bit         chk_en = 1'b0;

  function automatic void build_frame();
    logic [7:0] cs;
    cs = 8'h00;
    exp_q.delete();
    for (int r = 0; r < 8; r++) begin
      exp_q.push_back({1'b1, 4'b0000, 3'(r)});
      for (int b = 7; b >= 0; b--)
        exp_q.push_back({1'b1, 1'b1, regs[r][b], 1'b0, 1'b0, 3'(r)});
      cs = cs ^ regs[r];
    end
    for (int b = 7; b >= 0; b--)
      exp_q.push_back({1'b1, 1'b1, cs[b], (b == 0), 1'b0, 3'd7});
    exp_q.push_back({1'b1, 3'b000, 1'b1, 3'd7});
  endfunction

  always @(posedge Clk) begin
    if (Rst) begin
      exp_q.delete();
      cur = 8'h00;
    end else if (Cen) begin
      if (cur[7]) begin
        if (Abort) begin
          exp_q.delete();
          cur = 8'h00;
        end else if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
        end else begin
          cur = 8'h00;
        end
      end else if (Start) begin
        build_frame();
        cur = exp_q.pop_front();
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      checks++;
      if ({Busy, SerValid, SerOut, SerLast, Done, RegSel} !== cur) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t: got %b expected %b (busy,valid,out,last,done,sel)",
                 $time, {Busy, SerValid, SerOut, SerLast, Done, RegSel}, cur);
      end
    end
  end

  // ---------------- monitor for literal checks ----------------
  bit cap_q[$];
  int busy_cnt, done_cnt, last_idx, fclk_cnt;
  bit fclk_en = 1'b0;

  always @(negedge Clk) begin
    if (Cen && !Rst) begin
      if (SerValid) begin
        cap_q.push_back(SerOut);
        if (SerLast) last_idx = cap_q.size();
      end
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
    end
    if (fclk_en && (Busy || Start)) fclk_cnt++;
  end

  function automatic logic [7:0] cap_byte(input int i);
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++)
      if (i * 8 + k < cap_q.size()) v = {v[6:0], cap_q[i * 8 + k]};
      else v = {v[6:0], 1'bx};
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_mon();
    cap_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    last_idx = 0;
  endtask

  task automatic start_frame();
    Start = 1'b1;
    Cen   = 1'b1;
    step();
    Start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge Clk);
      if (!Busy) break;
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL %s: Busy still %b after %0d cycles, required 0", name, Busy, budget);
    end
    step();
  endtask

  task automatic set_regs_seq();
    for (int r = 0; r < 8; r++) regs[r] = 8'(r + 1);
  endtask

  task automatic check_seq_frame(input string name);
    check({name, "_bits"}, cap_q.size(), 72);
    for (int r = 0; r < 8; r++) check({name, "_byte"}, cap_byte(r), 32'(r + 1));
    check({name, "_cksum"}, cap_byte(8), 32'h08);
    check({name, "_last_idx"}, last_idx, 72);
    check({name, "_done_cnt"}, done_cnt, 1);
    check({name, "_busy_cnt"}, busy_cnt, 81);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Rst = 1'b1; Cen = 1'b0; Start = 1'b0; Abort = 1'b0;
    for (int r = 0; r < 8; r++) regs[r] = 8'h00;
    repeat (2) step();
    // Start and Cen during reset must not launch a frame.
    Start = 1'b1; Cen = 1'b1;
    step();
    Start = 1'b0;
    chk_en = 1'b1;
    @(negedge Clk);
    check("reset_outputs", {Busy, SerValid, SerOut, SerLast, Done, RegSel}, 0);
    Rst = 1'b0;
    step();

    // Sequential registers 0x01..0x08.
    set_regs_seq();
    clear_mon();
    start_frame();
    wait_idle("seq_idle", 200);
    check_seq_frame("seq");

    // All ones: 64 ones then checksum 0x00.
    for (int r = 0; r < 8; r++) regs[r] = 8'hFF;
    clear_mon();
    start_frame();
    wait_idle("ff_idle", 200);
    check("ff_bits", cap_q.size(), 72);
    for (int r = 0; r < 8; r++) check("ff_byte", cap_byte(r), 32'hFF);
    check("ff_cksum", cap_byte(8), 32'h00);

    // All zeros: 72 zeros.
    for (int r = 0; r < 8; r++) regs[r] = 8'h00;
    clear_mon();
    start_frame();
    wait_idle("zero_idle", 200);
    check("zero_bits", cap_q.size(), 72);
    for (int r = 0; r < 9; r++) check("zero_byte", cap_byte(r), 32'h00);

    // Cen toggling every cycle: same bits, twice the clocks.
    set_regs_seq();
    clear_mon();
    fclk_cnt = 0;
    fclk_en = 1'b1;
    Cen = 1'b0; Start = 1'b1;
    step();
    Cen = 1'b1;
    step();
    Start = 1'b0; Cen = 1'b0;
    repeat (180) begin
      step();
      Cen = ~Cen;
    end
    Cen = 1'b1;
    fclk_en = 1'b0;
    wait_idle("cen_idle", 200);
    check("cen_frame_clocks", fclk_cnt, 164);
    check_seq_frame("cen");

    // Abort during SHIFT of R3.
    set_regs_seq();
    clear_mon();
    start_frame();
    begin
      int n;
      n = 0;
      while (n < 100) begin
        @(negedge Clk);
        if (RegSel == 3'd3 && SerValid) break;
        n++;
      end
      check("abort_reach_r3", (n < 100), 1);
    end
    Abort = 1'b1;
    @(posedge Clk);
    #1 Abort = 1'b0;
    @(negedge Clk);
    check("abort_busy", Busy, 0);
    check("abort_regsel", RegSel, 0);
    step();
    repeat (5) step();
    check("abort_no_done", done_cnt, 0);
    clear_mon();
    start_frame();
    wait_idle("post_abort_idle", 200);
    check_seq_frame("post_abort");

    // Rst during CKSUM.
    clear_mon();
    start_frame();
    begin
      int n;
      n = 0;
      while (n < 200) begin
        @(negedge Clk);
        if (cap_q.size() >= 66 && SerValid) break;
        n++;
      end
      check("rst_reach_cksum", (n < 200), 1);
    end
    Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    check("rst_cksum_outputs", {Busy, SerValid, SerOut, SerLast, Done, RegSel}, 0);
    step();
    clear_mon();
    start_frame();
    wait_idle("post_rst_idle", 200);
    check_seq_frame("post_rst");

    // Start held high: second frame only after returning to IDLE.
    for (int r = 0; r < 8; r++) regs[r] = 8'($urandom_range(0, 255));
    clear_mon();
    Start = 1'b1; Cen = 1'b1;
    repeat (120) step();
    Start = 1'b0;
    wait_idle("hold_idle", 200);
    check("hold_done_cnt", done_cnt, 2);
    check("hold_bits", cap_q.size(), 144);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 8; it++) begin
      Start = 1'b0; Abort = 1'b0; Cen = 1'b1;
      wait_idle("rand_idle", 300);
      for (int r = 0; r < 8; r++) regs[r] = 8'($urandom_range(0, 255));
      repeat (250) begin
        Cen   = ($urandom_range(0, 3) != 0);
        Start = ($urandom_range(0, 9) == 0);
        Abort = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    Start = 1'b0; Abort = 1'b0; Cen = 1'b1;
    wait_idle("final_idle", 300);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port Rst, input, 1 bit: synchronous, active-high reset; overrides Cen.
REQ-003 SHALL have port Cen, input, 1 bit: clock enable; when 0, all state and outputs hold and Start/Abort are ignored.
REQ-004 SHALL have port Start, input, 1 bit: request a dump of registers R0..R7; sampled only in IDLE.
REQ-005 SHALL have port Abort, input, 1 bit: terminate an in-progress dump.
REQ-006 SHALL have port RegData, input, 8 bits: combinational read data of the register addressed by RegSel.
REQ-007 SHALL have port RegSel, output, 3 bits: register index being read.
REQ-008 SHALL have port SerOut, output, 1 bit: serial data, MSB first.
REQ-009 SHALL have port SerValid, output, 1 bit: SerOut carries a valid bit this cycle.
REQ-010 SHALL have port SerLast, output, 1 bit: final bit of the frame (checksum LSB).
REQ-011 SHALL have port Busy, output, 1 bit: dump in progress (state not IDLE).
REQ-012 SHALL have port Done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-013 SHALL implement states IDLE, LOAD, SHIFT, CKSUM, DONE.
REQ-014 SHALL, in IDLE with Cen=1 and Start=1, go to LOAD with RegSel=0 and checksum register=0x00.
REQ-015 SHALL, in LOAD, capture RegData into an 8-bit shift register and XOR it into the checksum, then go to SHIFT with bit counter=0.
REQ-016 SHALL, in SHIFT and CKSUM, drive SerOut=shift register bit 7 and SerValid=1, shift left by one, and increment the bit counter on each enabled edge.
REQ-017 SHALL, on the SHIFT edge with bit counter=7 and RegSel<7, go to LOAD with RegSel+1.
REQ-018 SHALL, on the SHIFT edge with bit counter=7 and RegSel=7, load the shift register with the final checksum (XOR of all 8 captured bytes), reset the bit counter, and go to CKSUM.
REQ-019 SHALL, on the CKSUM edge with bit counter=7, go to DONE; SerLast=1 only during that cycle.
REQ-020 SHALL, in DONE, assert Done=1 for exactly one enabled cycle, then go to IDLE; a Start in DONE is ignored.
REQ-021 SHALL produce, per frame, exactly 72 SerValid cycles (64 data plus 8 checksum), with SerValid=0 in LOAD, DONE and IDLE.
REQ-022 SHALL make a normal frame last 82 enabled cycles from the Start-sampling edge to the return to IDLE.
REQ-023 SHALL, when Abort=1 and Cen=1 in any non-IDLE state, go to IDLE on that edge with no Done pulse; Abort in the same cycle as Start in IDLE is ignored.
REQ-024 SHALL make RegSel wrap never occur; RegSel holds 7 through CKSUM and DONE and returns to 0 in IDLE.
REQ-025 SHALL, when Cen=0 mid-frame, freeze SerOut, SerValid, SerLast, RegSel and counters; the bit resumes when Cen returns.

Reset
REQ-026 SHALL, on Rst=1 at a clock edge (any state, any Cen), set state=IDLE, RegSel=0, shift register=0, checksum=0, bit counter=0, and SerOut=SerValid=SerLast=Busy=Done=0.
REQ-027 SHALL make Rst mid-frame discard the frame; the next Start begins a fresh frame from R0.

Verification
REQ-028 SHALL verify: registers R0..R7=0x01..0x08, Start pulse, Cen=1 -> serial bytes 0x01..0x08 MSB first, then checksum 0x08, SerLast on bit 72, Done one cycle, Busy for 81 cycles.
REQ-029 SHALL verify: all registers=0xFF -> 64 ones, then checksum 0x00; all registers=0x00 -> 72 zeros.
REQ-030 SHALL verify: Cen toggling 1/0 every cycle during a frame -> identical bit sequence to REQ-028, and the frame takes 164 clocks.
REQ-031 SHALL verify: Abort during SHIFT of R3 -> next edge IDLE, Busy=0, Done never 1; a subsequent Start yields a complete correct frame.
REQ-032 SHALL verify: Rst during CKSUM -> all outputs 0 next cycle; Start held high during a frame -> no restart until IDLE.
